wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Program sequencer for the washing-machine controller. Owns the top-level machine state, runs the wash/rinse/dry phases step by step on a 1-tick time base, and drives the display/LED front end with `state`, the 10-bit LED vector `data`, and three digit codes. Sits between the debounced button/sensor inputs and the display block.

## Interface
- `FILL_T`, 2: ticks per water-in step
- `DRAIN_T`, 1: ticks per water-out step
- `SPIN_T`, 2: ticks per spin step
- `WASH_T`, 5: ticks of wash agitation
- `RINSE_T`, 3: ticks of rinse agitation
- `BEGIN_T`, 2: ticks of lamp-test after power-on
- `FINISH_T`, 3: ticks of finish display
- `cp` in 1: system clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `tick` in 1: one-cycle time-base pulse (1 tick = 1 displayed minute)
- `power_btn` in 1: debounced one-cycle pulse, power toggle
- `start_btn` in 1: debounced pulse, start / pause / resume
- `mode_btn` in 1: debounced pulse, cycle program
- `door_open` in 1: level, door sensor
- `state` out 3: 0 SHUTDOWN, 1 BEGIN, 2 SET, 3 RUN, 4 ERROR, 5 PAUSE, 6 FINISH
- `data` out 10: [9] set, [8] power, [7] wash-in, [6] wash, [5] rinse-out, [4] rinse-spin, [3] rinse-in, [2] rinse, [1] dry-out, [0] dry-spin
- `inLeft` out 6: program number 1..7
- `inMiddle` out 6: remaining ticks, tens digit
- `inRight` out 6: remaining ticks, units digit

## Operation
- Program `prog` (3 bits, reset 7): bit2 wash, bit1 rinse, bit0 dry; 0 never reachable. `mode_btn` in SET only: 7 wraps to 1, else +1.
- Step order: W_FILL, W_AGIT (wash); R_DRAIN, R_SPIN, R_FILL, R_AGIT (rinse); D_DRAIN, D_SPIN (dry). Disabled phases skipped.
- `rem` (7 bits): loaded on RUN entry with sum of enabled phase times (wash 7, rinse 8, dry 3 at defaults; max 18; parameters must keep sum ≤ 99). `inMiddle`=rem/10, `inRight`=rem%10.
- Transitions (priority top-down, per cycle):
  - `power_btn`: SHUTDOWN→BEGIN; any other state→SHUTDOWN (step, rem cleared; prog kept).
  - BEGIN: after BEGIN_T ticks→SET.
  - SET: `start_btn` with `door_open`=0→RUN at first enabled step; with door open, ignored.
  - RUN: `door_open`→ERROR; else `start_btn`→PAUSE; else on `tick`: rem−1, step counter−1; step counter reaching 0 advances step; rem reaching 0→FINISH.
  - ERROR: `start_btn` with door closed→RUN (counters resume unchanged); door closing alone stays ERROR.
  - PAUSE: `door_open`→ERROR; `start_btn`→RUN.
  - FINISH: after FINISH_T ticks→SET, prog retained.
- `data`: [8]=1 in every state but SHUTDOWN. [9]=1 in SET only. SET: [6]=prog[2], [2]=prog[1], [0]=prog[0], others 0. RUN/PAUSE/ERROR: LED of current step lit, plus [6] during wash steps, [2] during rinse steps. BEGIN/FINISH: [7:0]=0 (display block forces them).
- `tick` ignored in SET, PAUSE, ERROR, SHUTDOWN.

## Timing
- All outputs registered; reset: state 0, data 0, inLeft 7, inMiddle 0, inRight 0, rem 0, step idle, prog 7.
- Button effect visible on outputs the cycle after the pulse.
- RUN entry: first step LED and full `rem` on the next cycle; first decrement on the first following `tick`.
- `tick` coincident with pause/error/power: the tick is dropped.
- Last tick: rem 1→0 and state→FINISH on the same edge; step LEDs clear.
- Reset mid-run: immediate return to reset values, no resume.

## Configuration
- `WASH_BLINK_EN` defined: in PAUSE and ERROR the current-step LED toggles on every `tick` (phase LED stays steady); returns steady on RUN re-entry.
- Not defined: step LED steady in PAUSE and ERROR.

## Test plan
- Reset, power_btn, 2 ticks → state 1 then 2, data=10'b11_0100_0101, inLeft=7.
- mode_btn ×7 in SET → inLeft 1,2,…,7,1 wrapping; data[6],[2],[0] track prog bits.
- prog 7, start, 18 ticks → rem 18→0, step LEDs in order 7,6,5,4,3,2 region…1,0; state 6 on 18th tick; 3 ticks later state 2.
- RUN, start_btn at rem=10 → state 5, 4 ticks leave rem=10; start → state 3, next tick rem=9.
- RUN, door_open=1 → state 4; start ignored while open; close + start → state 3 with same rem.
- prog 1 (dry only) → rem 3, data[1] for 1 tick, data[0] for 2 ticks, FINISH; power_btn mid-run → state 0, data 0.

Source files
------------

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: machine state, step timing and display codes.
// Optional `WASH_BLINK_EN: current-step LED toggles on each tick while paused or in error.
module wash_sequencer #(
    parameter int FILL_T   = 2,
    parameter int DRAIN_T  = 1,
    parameter int SPIN_T   = 2,
    parameter int WASH_T   = 5,
    parameter int RINSE_T  = 3,
    parameter int BEGIN_T  = 2,
    parameter int FINISH_T = 3
) (
    input  logic       cp,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       power_btn,
    input  logic       start_btn,
    input  logic       mode_btn,
    input  logic       door_open,
    output logic [2:0] state,
    output logic [9:0] data,
    output logic [5:0] inLeft,
    output logic [5:0] inMiddle,
    output logic [5:0] inRight
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_BEGIN = 3'd1,
        S_SET   = 3'd2,
        S_RUN   = 3'd3,
        S_ERR   = 3'd4,
        S_PAUSE = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_WFILL  = 4'd1;
    localparam logic [3:0] ST_WAGIT  = 4'd2;
    localparam logic [3:0] ST_RDRAIN = 4'd3;
    localparam logic [3:0] ST_RSPIN  = 4'd4;
    localparam logic [3:0] ST_RFILL  = 4'd5;
    localparam logic [3:0] ST_RAGIT  = 4'd6;
    localparam logic [3:0] ST_DDRAIN = 4'd7;
    localparam logic [3:0] ST_DSPIN  = 4'd8;

`ifdef WASH_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    function automatic logic [6:0] f_dur(input logic [3:0] s);
        case (s)
            ST_WFILL, ST_RFILL:   f_dur = 7'(FILL_T);
            ST_WAGIT:             f_dur = 7'(WASH_T);
            ST_RDRAIN, ST_DDRAIN: f_dur = 7'(DRAIN_T);
            ST_RSPIN, ST_DSPIN:   f_dur = 7'(SPIN_T);
            ST_RAGIT:             f_dur = 7'(RINSE_T);
            default:              f_dur = 7'd0;
        endcase
    endfunction

    function automatic logic f_en(input int k, input logic [2:0] p);
        if (k <= 2)      f_en = p[2];
        else if (k <= 6) f_en = p[1];
        else             f_en = p[0];
    endfunction

    // First enabled step strictly after cur; idle when the program is exhausted.
    function automatic logic [3:0] f_next(input logic [3:0] cur,
                                          input logic [2:0] p);
        f_next = ST_IDLE;
        for (int k = 8; k >= 1; k--) begin
            if (k > int'(cur) && f_en(k, p)) f_next = 4'(k);
        end
    endfunction

    function automatic logic [6:0] f_total(input logic [2:0] p);
        f_total = (p[2] ? 7'(FILL_T + WASH_T) : 7'd0)
                + (p[1] ? 7'(DRAIN_T + SPIN_T + FILL_T + RINSE_T) : 7'd0)
                + (p[0] ? 7'(DRAIN_T + SPIN_T) : 7'd0);
    endfunction

    function automatic logic [9:0] f_leds(input state_t st,
                                          input logic [3:0] s,
                                          input logic [2:0] p,
                                          input logic b);
        f_leds = '0;
        case (st)
            S_BEGIN, S_FIN: f_leds[8] = 1'b1;
            S_SET: f_leds = {2'b11, 1'b0, p[2], 3'b000, p[1], 1'b0, p[0]};
            S_RUN, S_ERR, S_PAUSE: begin
                f_leds[8] = 1'b1;
                if (s != ST_IDLE && !(b && st != S_RUN))
                    f_leds[4'd8 - s] = 1'b1;
                if (s == ST_WFILL || s == ST_WAGIT) f_leds[6] = 1'b1;
                if (s >= ST_RDRAIN && s <= ST_RAGIT) f_leds[2] = 1'b1;
            end
            default: f_leds = '0;
        endcase
    endfunction

    state_t     r_state, w_state;
    logic [3:0] r_step, w_step;
    logic [6:0] r_scnt, w_scnt;
    logic [6:0] r_rem, w_rem;
    logic [2:0] r_prog, w_prog;
    logic [6:0] r_tcnt, w_tcnt;
    logic       r_blink, w_blink;
    logic [9:0] r_data;
    logic [5:0] r_left, r_mid, r_right;
    logic [3:0] w_first, w_after;

    assign w_first = f_next(ST_IDLE, r_prog);
    assign w_after = f_next(r_step, r_prog);

    always_comb begin
        w_state = r_state;
        w_step  = r_step;
        w_scnt  = r_scnt;
        w_rem   = r_rem;
        w_prog  = r_prog;
        w_tcnt  = r_tcnt;
        w_blink = r_blink;
        if (power_btn) begin
            if (r_state == S_OFF) begin
                w_state = S_BEGIN;
                w_tcnt  = 7'(BEGIN_T);
            end else begin
                w_state = S_OFF;
                w_step  = ST_IDLE;
                w_scnt  = '0;
                w_rem   = '0;
                w_tcnt  = '0;
                w_blink = 1'b0;
            end
        end else begin
            case (r_state)
                S_BEGIN, S_FIN: begin
                    if (tick) begin
                        if (r_tcnt <= 7'd1) w_state = S_SET;
                        else w_tcnt = r_tcnt - 7'd1;
                    end
                end
                S_SET: begin
                    if (start_btn && !door_open) begin
                        w_state = S_RUN;
                        w_step  = w_first;
                        w_scnt  = f_dur(w_first);
                        w_rem   = f_total(r_prog);
                        w_blink = 1'b0;
                    end else if (mode_btn) begin
                        w_prog = (r_prog == 3'd7) ? 3'd1 : r_prog + 3'd1;
                    end
                end
                S_RUN: begin
                    if (door_open) begin
                        w_state = S_ERR;
                    end else if (start_btn) begin
                        w_state = S_PAUSE;
                    end else if (tick) begin
                        w_rem = r_rem - 7'd1;
                        if (r_rem <= 7'd1) begin
                            w_state = S_FIN;
                            w_step  = ST_IDLE;
                            w_scnt  = '0;
                            w_tcnt  = 7'(FINISH_T);
                        end else if (r_scnt <= 7'd1) begin
                            w_step = w_after;
                            w_scnt = f_dur(w_after);
                        end else begin
                            w_scnt = r_scnt - 7'd1;
                        end
                    end
                end
                S_ERR: begin
                    if (start_btn && !door_open) begin
                        w_state = S_RUN;
                        w_blink = 1'b0;
                    end else if (tick) begin
                        w_blink = r_blink ^ BLINK;
                    end
                end
                S_PAUSE: begin
                    if (door_open) begin
                        w_state = S_ERR;
                    end else if (start_btn) begin
                        w_state = S_RUN;
                        w_blink = 1'b0;
                    end else if (tick) begin
                        w_blink = r_blink ^ BLINK;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OFF;
            r_step  <= ST_IDLE;
            r_scnt  <= '0;
            r_rem   <= '0;
            r_prog  <= 3'd7;
            r_tcnt  <= '0;
            r_blink <= 1'b0;
            r_data  <= '0;
            r_left  <= 6'd7;
            r_mid   <= '0;
            r_right <= '0;
        end else begin
            r_state <= w_state;
            r_step  <= w_step;
            r_scnt  <= w_scnt;
            r_rem   <= w_rem;
            r_prog  <= w_prog;
            r_tcnt  <= w_tcnt;
            r_blink <= w_blink;
            r_data  <= f_leds(w_state, w_step, w_prog, w_blink);
            r_left  <= {3'b000, w_prog};
            r_mid   <= 6'(w_rem / 7'd10);
            r_right <= 6'(w_rem % 7'd10);
        end
    end

    assign state    = r_state;
    assign data     = r_data;
    assign inLeft   = r_left;
    assign inMiddle = r_mid;
    assign inRight  = r_right;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed program walk-throughs plus random button/door/tick
// traffic, checked each cycle against a timeline model of the wash program.
module tb_wash_sequencer;

    logic       cp = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       power_btn = 1'b0;
    logic       start_btn = 1'b0;
    logic       mode_btn = 1'b0;
    logic       door_open = 1'b0;
    logic [2:0] state;
    logic [9:0] data;
    logic [5:0] inLeft, inMiddle, inRight;

    int n_chk = 0;
    int n_pass = 0;

    // Program timeline: step LED, duration, and which prog bit enables it.
    int DUR[8] = '{2, 5, 1, 2, 2, 3, 1, 2};
    int LED[8] = '{7, 6, 5, 4, 3, 2, 1, 0};
    int GRP[8] = '{2, 2, 1, 1, 1, 1, 0, 0};

    int m_state, m_prog, m_total, m_el, m_tc;
    bit m_blink;

    wash_sequencer dut (
        .cp(cp), .rst_n(rst_n), .tick(tick), .power_btn(power_btn),
        .start_btn(start_btn), .mode_btn(mode_btn), .door_open(door_open),
        .state(state), .data(data), .inLeft(inLeft),
        .inMiddle(inMiddle), .inRight(inRight)
    );

    always #5 cp = ~cp;

    function automatic bit en(int i, int p);
        return ((p >> GRP[i]) & 1) == 1;
    endfunction

    function automatic int total_of(int p);
        int t = 0;
        for (int i = 0; i < 8; i++) if (en(i, p)) t += DUR[i];
        return t;
    endfunction

    function automatic logic [9:0] exp_data();
        logic [9:0] d = '0;
        int cum = 0;
        case (m_state)
            1, 6: d[8] = 1'b1;
            2: begin
                d[9] = 1'b1;
                d[8] = 1'b1;
                d[6] = ((m_prog >> 2) & 1) == 1;
                d[2] = ((m_prog >> 1) & 1) == 1;
                d[0] = (m_prog & 1) == 1;
            end
            3, 4, 5: begin
                d[8] = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    if (en(i, m_prog)) begin
                        if (m_el >= cum && m_el < cum + DUR[i]) begin
                            if (!(m_blink && m_state != 3)) d[LED[i]] = 1'b1;
                            if (GRP[i] == 2) d[6] = 1'b1;
                            if (GRP[i] == 1) d[2] = 1'b1;
                        end
                        cum += DUR[i];
                    end
                end
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    task automatic model_reset();
        m_state = 0; m_prog = 7; m_total = 0; m_el = 0; m_tc = 0; m_blink = 0;
    endtask

    task automatic blink_toggle();
`ifdef WASH_BLINK_EN
        m_blink = !m_blink;
`endif
    endtask

    task automatic model_step(bit t, bit p, bit s, bit md, bit dr);
        if (p) begin
            if (m_state == 0) begin
                m_state = 1; m_tc = 0;
            end else begin
                m_state = 0; m_total = 0; m_el = 0; m_blink = 0;
            end
        end else begin
            case (m_state)
                1: if (t) begin m_tc++; if (m_tc == 2) m_state = 2; end
                2: if (s && !dr) begin
                       m_state = 3; m_total = total_of(m_prog); m_el = 0; m_blink = 0;
                   end else if (md) m_prog = (m_prog == 7) ? 1 : m_prog + 1;
                3: if (dr) m_state = 4;
                   else if (s) m_state = 5;
                   else if (t) begin
                       m_el++;
                       if (m_el == m_total) begin m_state = 6; m_tc = 0; end
                   end
                4: if (s && !dr) begin m_state = 3; m_blink = 0; end
                   else if (t) blink_toggle();
                5: if (dr) m_state = 4;
                   else if (s) begin m_state = 3; m_blink = 0; end
                   else if (t) blink_toggle();
                6: if (t) begin m_tc++; if (m_tc == 3) m_state = 2; end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int rem = m_total - m_el;
        check("state", 32'(state), m_state);
        check("data", 32'(data), 32'(exp_data()));
        check("inLeft", 32'(inLeft), m_prog);
        check("inMiddle", 32'(inMiddle), rem / 10);
        check("inRight", 32'(inRight), rem % 10);
    endtask

    task automatic cyc(bit t, bit p, bit s, bit md);
        tick = t; power_btn = p; start_btn = s; mode_btn = md;
        @(posedge cp);
        model_step(t, p, s, md, door_open);
        #1;
        tick = 0; power_btn = 0; start_btn = 0; mode_btn = 0;
        check_all();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_data"}, 32'(data), 0);
        check({tag, "_left"}, 32'(inLeft), 7);
        check({tag, "_mid"}, 32'(inMiddle), 0);
        check({tag, "_right"}, 32'(inRight), 0);
    endtask

    initial begin
        model_reset();
        @(posedge cp); @(posedge cp); #1;
        check_reset_vals("reset");
        rst_n = 1;

        cyc(0, 1, 0, 0);
        check("begin_state", 32'(state), 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("set_state", 32'(state), 2);
        check("set_data", 32'(data), 32'(10'b11_0100_0101));

        for (int k = 1; k <= 7; k++) begin
            cyc(0, 0, 0, 1);
            check("mode_left", 32'(inLeft), k);
        end

        cyc(0, 0, 1, 0);
        check("run_entry_data", 32'(data), 32'h1C0);
        check("run_entry_tens", 32'(inMiddle), 1);
        check("run_entry_units", 32'(inRight), 8);
        for (int k = 1; k <= 18; k++) begin
            repeat ($urandom_range(0, 2)) cyc(0, 0, 0, 0);
            cyc(1, 0, 0, 0);
        end
        check("full_finish_state", 32'(state), 6);
        check("full_finish_data", 32'(data), 32'h100);
        repeat (3) cyc(1, 0, 0, 0);
        check("finish_to_set", 32'(state), 2);

        cyc(0, 0, 1, 0);
        repeat (8) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        check("pause_state", 32'(state), 5);
        repeat (4) cyc(1, 0, 0, 0);
        check("pause_tens", 32'(inMiddle), 1);
        check("pause_units", 32'(inRight), 0);
        cyc(0, 0, 1, 0);
        check("resume_state", 32'(state), 3);
        cyc(1, 0, 0, 0);
        check("resume_units", 32'(inRight), 9);

        door_open = 1;
        cyc(0, 0, 0, 0);
        check("error_state", 32'(state), 4);
        cyc(0, 0, 1, 0);
        check("error_start_open", 32'(state), 4);
        door_open = 0;
        cyc(0, 0, 0, 0);
        check("error_door_closed", 32'(state), 4);
        cyc(0, 0, 1, 0);
        check("error_resume", 32'(state), 3);
        check("error_resume_units", 32'(inRight), 9);
        repeat (9) cyc(1, 0, 0, 0);
        repeat (3) cyc(1, 0, 0, 0);

        cyc(0, 0, 0, 1);
        check("dry_prog", 32'(inLeft), 1);
        check("dry_set_data", 32'(data), 32'h301);
        cyc(0, 0, 1, 0);
        check("dry_rem", 32'(inRight), 3);
        check("dry_drain_led", 32'(data), 32'h102);
        cyc(1, 0, 0, 0);
        check("dry_spin_led", 32'(data), 32'h101);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("dry_finish", 32'(state), 6);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("power_off_state", 32'(state), 0);
        check("power_off_data", 32'(data), 0);

        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            if ($urandom_range(0, 99) < 2) door_open = !door_open;
            cyc($urandom_range(0, 99) < 35, r < 1, r >= 1 && r < 4,
                r >= 4 && r < 9);
        end

        door_open = 0;
        if (m_state != 0) cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(1, 0, 0, 0);
        #3 rst_n = 0;
        #1;
        check_reset_vals("midrun_reset");
        model_reset();
        @(posedge cp);
        #1 rst_n = 1;
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
